hazard_scoreboard: RTL

// Parametrised forwarding/stall unit. Replaces the fixed 2-stage forwarding logic.

---
 rtl/hazard_if.sv | 39 +++
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 2 files changed

// File: rtl/hazard_if.sv
// Decode-side bundle between the ID stage and the hazard scoreboard.
// The decoder (master) presents the instruction in ID plus the pipeline
// controls. The scoreboard (slave) returns the stall, the forward selects
// and the stall counter.
interface hazard_if #(
  parameter int DEPTH = 3,
  parameter int RW    = 5,
  parameter int LAT_W = 2,
  parameter int CNT_W = 16
);
  localparam int FW = $clog2(DEPTH + 1);

  logic             id_valid;
  logic [RW-1:0]    id_rs;
  logic [RW-1:0]    id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wen;
  logic [RW-1:0]    id_wsel;
  logic [LAT_W-1:0] id_lat;
  logic             flush;
  logic             mem_wait;
  logic             stall;
  logic [FW-1:0]    fwd_a;
  logic [FW-1:0]    fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    output id_wen, id_wsel, id_lat, flush, mem_wait,
    input  stall, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    input  id_wen, id_wsel, id_lat, flush, mem_wait,
    output stall, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Forwarding/stall unit beside decode. Keeps a DEPTH-entry shift tracker of
// in-flight register writes (entry 0 = EX). Each entry carries a countdown
// of cycles until its result can be forwarded. Decode stalls on the
// youngest matching producer that is not ready yet. Otherwise it forwards
// from that entry, or reads the regfile when nothing matches.
module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int RW    = 5,
  parameter int LAT_W = 2,
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  bus
);
  localparam int FW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] wen_q, wen_d;
  logic [RW-1:0]    wsel_q [DEPTH];
  logic [RW-1:0]    wsel_d [DEPTH];
  logic [LAT_W-1:0] rem_q  [DEPTH];
  logic [LAT_W-1:0] rem_d  [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             haz_a, haz_b;
  logic             stall;
  logic             push;
  logic [FW-1:0]    fwd_a, fwd_b;

  // Countdown that parks at zero once the result is forwardable.
  function automatic logic [LAT_W-1:0] rem_dec(input logic [LAT_W-1:0] r);
    return (r == '0) ? '0 : r - 1'b1;
  endfunction

  // Performance counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Youngest-match search. The scan runs oldest to youngest, so the lowest
  // matching index overwrites the older ones. Reg 0 and unused sources
  // never match.
  function automatic void lookup(input  logic [RW-1:0] r,
                                 input  logic          rd,
                                 output logic [FW-1:0] fwd,
                                 output logic          haz);
    fwd = '0;
    haz = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && wen_q[i] && (wsel_q[i] == r) && (r != '0) && rd) begin
        haz = (rem_q[i] != '0);
        fwd = haz ? '0 : FW'(i + 1);
      end
    end
  endfunction

  // Combinational forward select and stall for the instruction in ID.
  always_comb begin
    lookup(bus.id_rs, bus.id_use_rs, fwd_a, haz_a);
    lookup(bus.id_rt, bus.id_use_rt, fwd_b, haz_b);
    stall = bus.id_valid && !bus.flush && (haz_a || haz_b);
    push  = bus.id_valid && !stall && !bus.flush;
  end

  assign bus.stall     = stall;
  assign bus.fwd_a     = fwd_a;
  assign bus.fwd_b     = fwd_b;
  assign bus.stall_cnt = cnt_q;

  // Tracker advance: shift toward writeback with countdown, push the ID
  // instruction or a bubble into entry 0. Everything freezes on mem_wait,
  // and a flush that arrives during mem_wait is deliberately lost.
  always_comb begin
    vld_d  = vld_q;
    wen_d  = wen_q;
    wsel_d = wsel_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    if (!bus.mem_wait) begin
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i]  = vld_q[i-1];
        wen_d[i]  = wen_q[i-1];
        wsel_d[i] = wsel_q[i-1];
        rem_d[i]  = rem_dec(rem_q[i-1]);
      end
      vld_d[0]  = push;
      wen_d[0]  = bus.id_wen;
      wsel_d[0] = bus.id_wsel;
      rem_d[0]  = bus.id_lat;
      if (stall) begin
        cnt_d = sat_inc(cnt_q);
      end
    end
  end

  // State registers. Reset wins over mem_wait and clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      wen_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wsel_q[i] <= '0;
        rem_q[i]  <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      wen_q  <= wen_d;
      wsel_q <= wsel_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule
